alu_operand_sel: RTL
====================

Name: alu_operand_sel

Overview:
- Parametrised, registered successor to the ALU operand-B multiplexer.
- Selects one of NUM_SRC register/forwarding lanes or an internally extended immediate as the ALU operand.
- Buffers the result in a 2-entry skid FIFO with valid/ready handshakes on both sides, so the decode/operand stage can be decoupled from an ALU that stalls.
- Sits between the register file / forwarding network and the ALU operand-B input.

Parameters:
- WIDTH, 32: operand width in bits. Must be >= 16 and <= 32.
- NUM_SRC, 3: number of data lanes (lane 0 = ReadData2, lanes 1.. = forwarding paths).
- SEL_W, 2: select width. Must satisfy 2^SEL_W >= NUM_SRC+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream request valid
- in_ready  output  1  block can accept a request this cycle
- src_sel  input  SEL_W  0..NUM_SRC-1 = lane; NUM_SRC = extended immediate; above NUM_SRC = illegal
- src_data  input  NUM_SRC*WIDTH  packed lanes, lane k at [k*WIDTH +: WIDTH]
- imm  input  16  raw instruction immediate
- ext_mode  input  2  00 sign-extend, 01 zero-extend, 10 imm<<16 (upper immediate), 11 reserved
- out_valid  output  1  operand valid
- out_ready  input  1  ALU consumes operand
- alu_b  output  WIDTH  selected operand
- occupancy  output  2  entries held (0..2)
- sel_err  output  1  sticky illegal-select/illegal-mode flag

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - occupancy=0, out_valid=0, alu_b=0, sel_err=0, in_ready=1 on the following cycle.
  - A reset mid-transfer discards all buffered entries. No partial output is presented.
- Handshakes:
  - in_ready = (occupancy < 2), derived from registered state only, with no combinational path from out_ready.
  - Accept (push) when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - out_valid = (occupancy != 0). alu_b = head entry, or 0 when empty.
- Latency: an operand accepted at edge N appears on alu_b with out_valid at edge N, visible in cycle N+1, when the FIFO was empty. Otherwise it appears behind older entries, in strict FIFO order.
- Selection is evaluated at accept time, and the computed value is stored:
  - src_sel < NUM_SRC: the lane value.
  - src_sel == NUM_SRC: the extended immediate.
    - Mode 00: {{(WIDTH-16){imm[15]}}, imm}.
    - Mode 01: zero-extend.
    - Mode 10: (imm<<16) truncated to WIDTH; when WIDTH=16 the result is 0.
    - Mode 11: stored value 0 and sel_err set.
  - src_sel > NUM_SRC: stored value 0 and sel_err set. The entry is still pushed and still delivered.
  - Later changes to src_data or imm never alter buffered entries.
- Simultaneous push and pop:
  - occupancy unchanged, order preserved.
  - With occupancy=1, the head pops and the new entry becomes head on the next cycle.
  - With occupancy=2, in_ready=0, so only the pop occurs and occupancy becomes 1.
- Pop from empty and push when full cannot occur, because the handshake gating prevents them. Inputs while not ready are ignored with no state change.
- sel_err is sticky until reset. It does not affect the handshake.
- Storage is 2 entries of WIDTH bits plus a read pointer, write pointer and count. No combinational loops.

Test Plan:
- Reset, then a single transfer: src_sel=0, src_data lane0=32'h1234_5678, out_ready=1 -> next cycle out_valid=1, alu_b=32'h1234_5678; following cycle occupancy=0.
- Immediate modes: src_sel=3, imm=16'h8001 with ext_mode 00/01/10 -> alu_b = 32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000 in order, and sel_err stays 0.
- Backpressure: out_ready=0, push lanes 1 and 2 (values A, B) -> occupancy=2, in_ready=0, and a third request is ignored. Raise out_ready -> A then B on consecutive cycles, and in_ready returns to 1 after the first pop.
- Simultaneous push/pop at occupancy=1 -> occupancy stays 1 and the output order is exact.
- Illegal select: SEL_W=3, NUM_SRC=3, src_sel=5 -> alu_b=0 delivered and sel_err=1 thereafter. ext_mode=11 gives the same result.
- Reset mid-operation with occupancy=2 -> next cycle occupancy=0, out_valid=0, sel_err=0, in_ready=1.

Source files
------------

// File: rtl/alu_operand_sel.sv
// ALU operand-B selector: picks a forwarding lane or an extended immediate
// and queues the result in a 2-entry FIFO with valid/ready on both sides.
module alu_operand_sel #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [15:0]              imm,
  input  logic [1:0]               ext_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         alu_b,
  output logic [1:0]               occupancy,
  output logic                     sel_err
);

  // Immediate extension done at 32 bits, then truncated; mode 10 collapses to 0 at WIDTH=16.
  function automatic logic [WIDTH-1:0] ext_imm(input logic [15:0] v, input logic [1:0] m);
    logic [31:0] w;
    case (m)
      2'b00:   w = {{16{v[15]}}, v};
      2'b01:   w = {16'h0000, v};
      2'b10:   w = {v, 16'h0000};
      default: w = 32'h0000_0000;
    endcase
    return w[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] mem_r [2];
  logic             rd_ptr_r;
  logic             wr_ptr_r;
  logic [1:0]       count_r;
  logic             sel_err_r;

  logic [WIDTH-1:0] lane_s;
  logic [WIDTH-1:0] sel_val_s;
  logic             bad_s;
  logic             push_s;
  logic             pop_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign occupancy = count_r;
  assign sel_err   = sel_err_r;
  assign alu_b     = out_valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Lane mux as an OR of one-hot-gated lanes, so out-of-range selects yield zero.
  always_comb begin
    lane_s = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      lane_s = lane_s | ((src_sel == SEL_W'(k)) ? src_data[k*WIDTH +: WIDTH] : {WIDTH{1'b0}});
    end
  end

  // Value to store and illegal-request detection for the current request.
  always_comb begin
    sel_val_s = {WIDTH{1'b0}};
    bad_s     = 1'b0;
    if (src_sel < SEL_W'(NUM_SRC)) begin
      sel_val_s = lane_s;
    end else if (src_sel == SEL_W'(NUM_SRC)) begin
      sel_val_s = ext_imm(imm, ext_mode);
      bad_s     = (ext_mode == 2'b11);
    end else begin
      sel_val_s = {WIDTH{1'b0}};
      bad_s     = 1'b1;
    end
  end

  // FIFO storage, pointers, count and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_r[0]  <= {WIDTH{1'b0}};
      mem_r[1]  <= {WIDTH{1'b0}};
      rd_ptr_r  <= 1'b0;
      wr_ptr_r  <= 1'b0;
      count_r   <= 2'd0;
      sel_err_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= sel_val_s;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      if (push_s && bad_s) begin
        sel_err_r <= 1'b1;
      end
    end
  end

endmodule
